early_out_multiplier_pipe: RTL and testbench

Parametrised, fully handshaked successor to the team's early-out multiplier. Accepts operand pairs with a tag over valid/ready. Operands that fit in `SMALL_W` bits take a 1-cycle fast path; all others take a `PIPE_DEPTH`-cycle full-width path. Results leave strictly in acceptance order through a credit-protected output FIFO, so the block sits between any streaming producer and a back-pressuring consumer in the datapath.

---
 rtl/early_out_multiplier_pipe_if.sv | 27 ++
 rtl/early_out_multiplier_pipe.sv | 139 +++++++++++++
 tb/tb_early_out_multiplier_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/early_out_multiplier_pipe_if.sv
// Operand/result stream bundle for early_out_multiplier_pipe.
// The slave side is the multiplier; the master side is the producer/consumer pair.
interface early_out_multiplier_pipe_if #(
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned DOUT_W = 2 * DIN_W,
  parameter int unsigned TAG_W  = 4
);
  logic [DIN_W-1:0]  a_operand_i;
  logic [DIN_W-1:0]  b_operand_i;
  logic [TAG_W-1:0]  tag_i;
  logic              operands_valid_i;
  logic              operands_ready_o;
  logic [DOUT_W-1:0] product_o;
  logic [TAG_W-1:0]  tag_o;
  logic              product_valid_o;
  logic              product_ready_i;

  modport master (
    output a_operand_i, b_operand_i, tag_i, operands_valid_i, product_ready_i,
    input  operands_ready_o, product_o, tag_o, product_valid_o
  );

  modport slave (
    input  a_operand_i, b_operand_i, tag_i, operands_valid_i, product_ready_i,
    output operands_ready_o, product_o, tag_o, product_valid_o
  );
endinterface

// File: rtl/early_out_multiplier_pipe.sv
// Handshaked multiplier: small operands retire in one cycle, others through a PIPE_DEPTH pipeline;
// results leave in acceptance order through a credit-protected FWFT FIFO.
module early_out_multiplier_pipe #(
  parameter int unsigned DIN_W      = 8,
  parameter int unsigned DOUT_W     = 2 * DIN_W,
  parameter int unsigned SMALL_W    = (DIN_W + 1) / 2,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  early_out_multiplier_pipe_if.slave bus_io,
  output logic [31:0] fast_ops_o
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned Stages = PIPE_DEPTH - 1;
  localparam int unsigned ProdW  = 2 * DIN_W;
  localparam int unsigned FastW  = 2 * SMALL_W;

  function automatic logic is_small(input logic [DIN_W-1:0] x);
    if (SIGNED) begin
      return (x[DIN_W-1:SMALL_W-1] == '0) || (x[DIN_W-1:SMALL_W-1] == '1);
    end
    return x[DIN_W-1:SMALL_W] == '0;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CntW-1:0]   fifo_count_q, fifo_count_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]       fast_ops_q, fast_ops_d;
  logic [Stages-1:0] slow_vld_q;
  logic [DOUT_W-1:0] slow_prod_q [Stages];
  logic [TAG_W-1:0]  slow_tag_q [Stages];
  logic [DOUT_W-1:0] mem_prod_q [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag_q [FIFO_DEPTH];

  logic              ready, accept, fast_acc, slow_acc, slow_wr, push, pop, not_empty;
  logic [ProdW-1:0]  full_prod, fast_ext;
  logic [FastW-1:0]  fast_prod;
  logic [DOUT_W-1:0] wr_prod;
  logic [TAG_W-1:0]  wr_tag;

  // Credits count both queued and in-flight results, so the FIFO can never overflow.
  assign ready     = ~rst & (({1'b0, fifo_count_q} + {1'b0, inflight_q}) <
                             (CntW + 1)'(FIFO_DEPTH));
  assign accept    = bus_io.operands_valid_i & ready;
  // No slow op outstanding, otherwise a fast result would overtake it.
  assign fast_acc  = accept & is_small(bus_io.a_operand_i) & is_small(bus_io.b_operand_i) &
                     (inflight_q == '0);
  assign slow_acc  = accept & ~fast_acc;
  assign slow_wr   = slow_vld_q[Stages-1];
  assign push      = fast_acc | slow_wr;
  assign not_empty = fifo_count_q != '0;
  assign pop       = not_empty & bus_io.product_ready_i;

  always_comb begin
    if (SIGNED) begin
      full_prod = ProdW'($signed(bus_io.a_operand_i)) * ProdW'($signed(bus_io.b_operand_i));
      fast_prod = FastW'($signed(bus_io.a_operand_i[SMALL_W-1:0])) *
                  FastW'($signed(bus_io.b_operand_i[SMALL_W-1:0]));
    end else begin
      full_prod = ProdW'(bus_io.a_operand_i) * ProdW'(bus_io.b_operand_i);
      fast_prod = FastW'(bus_io.a_operand_i[SMALL_W-1:0]) *
                  FastW'(bus_io.b_operand_i[SMALL_W-1:0]);
    end
    fast_ext = {{(ProdW - FastW){SIGNED & fast_prod[FastW-1]}}, fast_prod};
    wr_prod  = fast_acc ? fast_ext[DOUT_W-1:0] : slow_prod_q[Stages-1];
    wr_tag   = fast_acc ? bus_io.tag_i : slow_tag_q[Stages-1];
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + 1'b1;
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - 1'b1;
    end
    inflight_d = inflight_q;
    if (slow_acc && !slow_wr) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!slow_acc && slow_wr) begin
      inflight_d = inflight_q - 1'b1;
    end
    fast_ops_d = fast_ops_q;
    if (fast_acc && fast_ops_q != '1) begin
      fast_ops_d = fast_ops_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count_q <= '0;
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fast_ops_q   <= '0;
      slow_vld_q   <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
      fast_ops_q   <= fast_ops_d;
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      slow_vld_q[0] <= slow_acc;
      for (int i = 1; i < Stages; i++) begin
        slow_vld_q[i] <= slow_vld_q[i-1];
      end
    end
  end

  // Datapath storage needs no reset: every use is qualified by a reset control bit.
  always_ff @(posedge clk) begin
    slow_prod_q[0] <= full_prod[DOUT_W-1:0];
    slow_tag_q[0]  <= bus_io.tag_i;
    for (int i = 1; i < Stages; i++) begin
      slow_prod_q[i] <= slow_prod_q[i-1];
      slow_tag_q[i]  <= slow_tag_q[i-1];
    end
    if (push) begin
      mem_prod_q[wr_ptr_q] <= wr_prod;
      mem_tag_q[wr_ptr_q]  <= wr_tag;
    end
  end

  assign bus_io.operands_ready_o = ready;
  assign bus_io.product_valid_o  = not_empty;
  assign bus_io.product_o        = not_empty ? mem_prod_q[rd_ptr_q] : '0;
  assign bus_io.tag_o            = not_empty ? mem_tag_q[rd_ptr_q] : '0;
  assign fast_ops_o              = fast_ops_q;

endmodule

// File: tb/tb_early_out_multiplier_pipe.sv
// Randomized scoreboard bench for early_out_multiplier_pipe (unsigned instance) plus
// directed latency, backpressure, reset and signed-mode checks.
module tb_early_out_multiplier_pipe;

  typedef struct {
    logic [15:0] prod;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] u_fast_ops, s_fast_ops;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          rand_rdy = 1'b0;
  exp_t        exp_q[$];
  int          seen_cyc[$];

  early_out_multiplier_pipe_if #(.DIN_W(8), .DOUT_W(16), .TAG_W(4)) u_if ();
  early_out_multiplier_pipe_if #(.DIN_W(8), .DOUT_W(16), .TAG_W(4)) s_if ();

  early_out_multiplier_pipe #(.SIGNED(1'b0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus_io     (u_if),
    .fast_ops_o (u_fast_ops)
  );

  early_out_multiplier_pipe #(.SIGNED(1'b1)) s_dut (
    .clk        (clk),
    .rst        (rst),
    .bus_io     (s_if),
    .fast_ops_o (s_fast_ops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // Scoreboard monitor for the unsigned instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && u_if.product_valid_o && u_if.product_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1'b0, longint'(u_if.product_o), 0);
      end else begin
        e = exp_q.pop_front();
        chk("product", u_if.product_o == e.prod, longint'(u_if.product_o), longint'(e.prod));
        chk("tag", u_if.tag_o == e.tag, longint'(u_if.tag_o), longint'(e.tag));
        seen_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      u_if.product_ready_i = 1'($urandom_range(1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                      output int acc);
    int n;
    exp_t e;
    u_if.a_operand_i      = a;
    u_if.b_operand_i      = b;
    u_if.tag_i            = t;
    u_if.operands_valid_i = 1'b1;
    n   = 0;
    acc = -1;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      if (u_if.operands_ready_o) begin
        acc    = cyc;
        e.prod = ref_mul(a, b);
        e.tag  = t;
        exp_q.push_back(e);
      end
      n++;
    end
    if (acc < 0) chk("accept_timeout", 1'b0, 0, 1);
    @(posedge clk);
    #1;
    u_if.operands_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size() == 0, longint'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lat(input string name, input int idx, input int k, input int lat);
    if (seen_cyc.size() > idx) chk(name, seen_cyc[idx] - k == lat, seen_cyc[idx] - k, lat);
    else chk(name, 1'b0, -1, lat);
  endtask

  task automatic s_check(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int lat);
    int k, c, n;
    logic [15:0] got;
    s_if.a_operand_i      = a;
    s_if.b_operand_i      = b;
    s_if.tag_i            = 4'h5;
    s_if.operands_valid_i = 1'b1;
    k = -1;
    n = 0;
    while (k < 0 && n < 20) begin
      @(negedge clk);
      if (s_if.operands_ready_o) k = cyc;
      n++;
    end
    @(posedge clk);
    #1;
    s_if.operands_valid_i = 1'b0;
    c   = -1;
    got = '0;
    n   = 0;
    while (c < 0 && n < 20) begin
      @(negedge clk);
      if (s_if.product_valid_o) begin
        c   = cyc;
        got = s_if.product_o;
      end
      n++;
    end
    chk({name, "_lat"}, k >= 0 && c >= 0 && c - k == lat, c - k, lat);
    chk({name, "_val"}, got == exp, longint'(got), longint'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, k2, idx, acc_n, stale, n;
    logic [7:0] bp_a [6];
    logic [7:0] bp_b [6];
    logic [7:0] ra, rb;
    exp_t e;

    u_if.a_operand_i = '0; u_if.b_operand_i = '0; u_if.tag_i = '0;
    u_if.operands_valid_i = 1'b0; u_if.product_ready_i = 1'b1;
    s_if.a_operand_i = '0; s_if.b_operand_i = '0; s_if.tag_i = '0;
    s_if.operands_valid_i = 1'b0; s_if.product_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", u_if.operands_ready_o == 1'b0, longint'(u_if.operands_ready_o), 0);
    chk("rst_valid", u_if.product_valid_o == 1'b0, longint'(u_if.product_valid_o), 0);
    chk("rst_product", u_if.product_o == 16'h0, longint'(u_if.product_o), 0);
    chk("rst_tag", u_if.tag_o == 4'h0, longint'(u_if.tag_o), 0);
    chk("rst_fast_ops", u_fast_ops == 32'd0, longint'(u_fast_ops), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", u_if.operands_ready_o == 1'b1, longint'(u_if.operands_ready_o), 1);
    @(posedge clk);
    #1;

    // Fast path
    seen_cyc.delete();
    send(8'd3, 8'd5, 4'd1, k);
    drain();
    chk_lat("fast_latency", 0, k, 1);
    chk("fast_ops_1", u_fast_ops == 32'd1, longint'(u_fast_ops), 1);

    // Slow path
    seen_cyc.delete();
    send(8'd200, 8'd100, 4'd2, k);
    drain();
    chk_lat("slow_latency", 0, k, 3);
    chk("fast_ops_slow", u_fast_ops == 32'd1, longint'(u_fast_ops), 1);

    // Slow followed by small: small is forced slow and retires one cycle later
    seen_cyc.delete();
    send(8'd200, 8'd2, 4'd3, k);
    send(8'd3, 8'd3, 4'd4, k2);
    drain();
    chk("hazard_b2b", k2 == k + 1, k2 - k, 1);
    chk_lat("hazard_first", 0, k, 3);
    chk_lat("hazard_second", 1, k, 4);
    chk("fast_ops_hazard", u_fast_ops == 32'd1, longint'(u_fast_ops), 1);

    // Backpressure: only FIFO_DEPTH credits
    bp_a = '{8'd3, 8'd5, 8'd100, 8'd2, 8'd250, 8'd9};
    bp_b = '{8'd4, 8'd6, 8'd3, 8'd2, 8'd250, 8'd9};
    u_if.product_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      u_if.a_operand_i = bp_a[idx]; u_if.b_operand_i = bp_b[idx];
      u_if.tag_i = 4'(idx + 8); u_if.operands_valid_i = 1'b1;
      @(negedge clk);
      if (u_if.operands_ready_o) begin
        e.prod = ref_mul(bp_a[idx], bp_b[idx]);
        e.tag  = 4'(idx + 8);
        exp_q.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    acc_n = idx;
    chk("bp_accepted", acc_n == 4, acc_n, 4);
    @(negedge clk);
    chk("bp_ready_low", u_if.operands_ready_o == 1'b0, longint'(u_if.operands_ready_o), 0);
    @(posedge clk);
    #1;
    u_if.product_ready_i = 1'b1;
    n = 0;
    while (idx < 6 && n < 100) begin
      u_if.a_operand_i = bp_a[idx]; u_if.b_operand_i = bp_b[idx];
      u_if.tag_i = 4'(idx + 8); u_if.operands_valid_i = 1'b1;
      @(negedge clk);
      if (u_if.operands_ready_o) begin
        e.prod = ref_mul(bp_a[idx], bp_b[idx]);
        e.tag  = 4'(idx + 8);
        exp_q.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    u_if.operands_valid_i = 1'b0;
    chk("bp_all_accepted", idx == 6, idx, 6);
    drain();
    chk("fast_ops_bp", u_fast_ops == 32'd3, longint'(u_fast_ops), 3);

    // Signed instance
    s_check("signed_fast", 8'hFD, 8'h07, 16'hFFEB, 1);
    s_check("signed_slow", 8'h9C, 8'h02, 16'hFF38, 3);
    chk("signed_fast_ops", s_fast_ops == 32'd1, longint'(s_fast_ops), 1);

    // Randomized traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(2))
        0: begin ra = 8'($urandom_range(15));  rb = 8'($urandom_range(15));  end
        1: begin ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255)); end
        default: begin ra = 8'($urandom_range(255)); rb = 8'($urandom_range(15)); end
      endcase
      send(ra, rb, 4'($urandom_range(15)), k);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    u_if.product_ready_i = 1'b1;
    drain();

    // Reset with two slow ops in flight
    send(8'd200, 8'd100, 4'd6, k);
    send(8'd150, 8'd3, 4'd7, k2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (u_if.product_valid_o) stale++;
    end
    chk("no_stale_after_rst", stale == 0, stale, 0);
    chk("fast_ops_after_rst", u_fast_ops == 32'd0, longint'(u_fast_ops), 0);
    @(posedge clk);
    #1;
    seen_cyc.delete();
    send(8'd7, 8'd9, 4'd9, k);
    drain();
    chk_lat("post_rst_latency", 0, k, 1);
    seen_cyc.delete();
    send(8'd77, 8'd9, 4'd10, k);
    drain();
    chk_lat("post_rst_slow_latency", 0, k, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
